tx_arbiter: RTL and testbench
=============================

# tx_arbiter

Controller that shares a single `tx_module` serial transmitter between `N_REQ` requesters. Each requester presents a byte with a request/grant handshake. The arbiter chooses one requester, latches its byte, and sequences `tx_module` through one full frame. It then enforces an idle gap before serving the next requester. It sits between the parallel-side clients and `tx_module`, and it is the only driver of `tx_module`'s `reset`, `enable` and `data_in`.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `DATA_W`, default 8: width of the payload per frame.
- `FRAME_BITS`, default 11: serial length of one `tx_module` frame (start, 8 data, parity, stop), one bit per `clk`.
- `GAP`, default 1: idle cycles between frames, range 0..15.
- `clk` input, 1: single clock; all logic on its rising edge.
- `reset` input, 1: synchronous, active-low reset.
- `req` input, `N_REQ`: per-requester request level.
- `req_data` input, `N_REQ*DATA_W`: payload of requester i on bits [i*DATA_W +: DATA_W].
- `grant` output, `N_REQ`: one-hot, one-cycle pulse; the payload was accepted in this cycle.
- `owner` output, clog2(`N_REQ`): index of the requester currently being transmitted.
- `busy` output, 1: high whenever the FSM is not in IDLE.
- `tx_reset` output, 1: active-high; drives `tx_module.reset`.
- `tx_enable` output, 1: drives `tx_module.enable`.
- `tx_data` output, `DATA_W`: drives `tx_module.data_in`; it is a registered copy of the latched payload.

## Operation
- FSM states are IDLE, LOAD, SEND and GAP. All outputs are registered.
- **IDLE:** samples `req`.
  - If any bit is set, select a winner, latch `req_data[winner]` into `tx_data`, set `owner`, and pulse `grant[winner]`. Next state is LOAD.
  - Otherwise stay in IDLE.
- **LOAD:** one cycle. `tx_reset`=1 and `tx_enable`=1. The `grant` pulse is visible in this cycle. Next state is SEND.
- **SEND:** `tx_reset`=0 and `tx_enable`=1. A bit counter runs from 0 to `FRAME_BITS`-1. On the terminal count:
  - If `GAP`>0, go to GAP.
  - If `GAP`=0, arbitrate immediately as in IDLE, going to LOAD on a hit or IDLE otherwise.
- **GAP:** `tx_enable`=0. Counts `GAP` cycles, then arbitrates exactly as in IDLE.
- **Arbitration (default: round-robin):**
  - The search starts at `last_winner+1` modulo `N_REQ` and takes the first set `req` bit.
  - `last_winner` updates only when a grant is issued.
- **Requester rules:**
  - Hold `req` and `req_data` stable until `grant` is seen.
  - Dropping `req` before `grant` withdraws the request; no grant is issued.
  - `req` still high after `grant` is treated as a new request for the next frame.
- `tx_data` and `owner` remain constant from LOAD through the end of GAP.
- **Reset** (`reset`=0 at a rising edge, in any state, including mid-frame):
  - Next state is IDLE. The frame is abandoned; no `grant` is issued.
  - Output values: `grant`=0, `busy`=0, `tx_enable`=0, `tx_reset`=1, `tx_data`=0, `owner`=0.
  - Internal state: `last_winner`=`N_REQ`-1, so requester 0 is searched first. The bit counter and gap counter are 0.
  - `tx_reset` stays 1 while `reset` is low and falls in the first cycle after reset is released.

## Timing
- With `req[i]` sampled high in IDLE at edge t:
  - Edges t..t+1: `grant[i]`, `tx_data`, `owner`, `busy` and `tx_reset` are valid (LOAD).
  - Edge t+1: SEND begins.
  - Edges t+1..t+1+`FRAME_BITS`: `tx_enable` is high for `FRAME_BITS` cycles.
- **Throughput:** one frame per `FRAME_BITS`+`GAP`+1 cycles while requests are pending.
- **Simultaneous events:**
  - A `req` that rises during SEND or GAP is considered only at the next arbitration point.
  - A `reset` edge overrides every FSM transition in the same cycle.

## Configuration
- Macro `TX_ARB_FIXED_PRIO_EN`.
  - Defined: fixed priority; the lowest set `req` index always wins, and `last_winner` is unused.
  - Undefined: round-robin as specified above.

## Test plan
- **Single request:** reset, then `req`=4'b0100 with data 8'hA5 → one `grant`=4'b0100 pulse, `owner`=2, `tx_data`=8'hA5, `tx_enable` high for 11 cycles, `busy` low 13 cycles after grant (`GAP`=1).
- **Round-robin fairness:** `req`=4'b1111 held, each requester re-asserting after its grant → grant order 0,1,2,3,0, spaced 13 cycles apart.
- **Two-way contention:** `req`=4'b1001 after requester 0 was just served → requester 3 wins next. With `TX_ARB_FIXED_PRIO_EN` defined, requester 0 wins every time.
- **Withdrawn request:** `req[1]` pulsed for one cycle during SEND → no `grant[1]`, FSM returns to IDLE after GAP.
- **Reset mid-frame:** `reset`=0 at SEND bit 5 → next cycle `tx_reset`=1, `tx_enable`=0, `busy`=0, `owner`=0. After release, with `req`=4'b1111, requester 0 is granted first.
- **`GAP`=0 back-to-back:** `req`=4'b0011 held → the second LOAD follows the terminal SEND cycle directly, and `tx_enable` never drops between frames.

Source files
------------

// File: rtl/tx_arbiter_if.sv
// Parallel-side request/grant bus plus the tx_module drive lines of tx_arbiter.
// master = the arbiter, slave = the requester side and tx_module.
interface tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        grant;
  logic [OW-1:0]           owner;
  logic                    busy;
  logic                    tx_reset;
  logic                    tx_enable;
  logic [DATA_W-1:0]       tx_data;

  modport master (
    input  req, req_data,
    output grant, owner, busy, tx_reset, tx_enable, tx_data
  );

  modport slave (
    output req, req_data,
    input  grant, owner, busy, tx_reset, tx_enable, tx_data
  );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one tx_module between N_REQ requesters (IDLE/LOAD/SEND/GAP).
// Define TX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int FRAME_BITS = 11,
  parameter int GAP        = 1
) (
  input logic          clk,
  input logic          reset,
  tx_arbiter_if.master bus
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} state_t;

  state_t        state;
  logic [OW-1:0] last_winner;
  logic [BW-1:0] bit_cnt;
  logic [3:0]    gap_cnt;
  logic          arb_pt;
  logic          hit;
  logic [OW-1:0] win;

  // Returns {found, index}; descending scan so the earliest candidate in search order wins.
  function automatic logic [OW:0] pick(input logic [N_REQ-1:0] r, input logic [OW-1:0] last);
    logic [OW:0] res;
    res = '0;
`ifdef TX_ARB_FIXED_PRIO_EN
    for (int k = N_REQ - 1; k >= 0; k--)
      if (r[k]) res = {1'b1, OW'(k)};
`else
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % N_REQ;
      if (r[idx]) res = {1'b1, OW'(idx)};
    end
`endif
    return res;
  endfunction

  always_comb begin
    arb_pt = (state == ST_IDLE) ||
             (state == ST_SEND && bit_cnt == BIT_LAST && GAP == 0) ||
             (state == ST_GAP  && gap_cnt == GAP_LAST);
    {hit, win} = pick(bus.req, last_winner);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      last_winner   <= OW'(N_REQ - 1);
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      bus.grant     <= '0;
      bus.owner     <= '0;
      bus.busy      <= 1'b0;
      bus.tx_reset  <= 1'b1;
      bus.tx_enable <= 1'b0;
      bus.tx_data   <= '0;
    end else begin
      bus.grant <= '0;
      if (arb_pt) begin
        if (hit) begin
          state         <= ST_LOAD;
          last_winner   <= win;
          bus.grant     <= N_REQ'(1) << win;
          bus.owner     <= win;
          bus.tx_data   <= bus.req_data[win*DATA_W +: DATA_W];
          bus.busy      <= 1'b1;
          bus.tx_reset  <= 1'b1;
          bus.tx_enable <= 1'b1;
        end else begin
          state         <= ST_IDLE;
          bus.busy      <= 1'b0;
          bus.tx_reset  <= 1'b0;
          bus.tx_enable <= 1'b0;
        end
      end else begin
        case (state)
          ST_LOAD: begin
            state         <= ST_SEND;
            bit_cnt       <= '0;
            bus.busy      <= 1'b1;
            bus.tx_reset  <= 1'b0;
            bus.tx_enable <= 1'b1;
          end
          // Terminal count only lands here when GAP > 0; GAP == 0 is an arbitration point.
          ST_SEND: begin
            if (bit_cnt == BIT_LAST) begin
              state         <= ST_GAP;
              gap_cnt       <= '0;
              bus.tx_enable <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_GAP:  gap_cnt <= gap_cnt + 1'b1;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus randomized traffic
// compared against a frame-timing reference model (GAP=1 instance and a GAP=0 instance).
module tb_tx_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int FB  = 11;
  localparam int GP  = 1;
  localparam int PER = FB + GP + 1;

  logic clk = 1'b0;
  logic reset;
  logic reset0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();
  tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus0 ();

  tx_arbiter #(.N_REQ(N), .DATA_W(DW), .FRAME_BITS(FB), .GAP(GP)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  tx_arbiter #(.N_REQ(N), .DATA_W(DW), .FRAME_BITS(FB), .GAP(0)) dut0 (
    .clk(clk), .reset(reset0), .bus(bus0));

  // Reference model: a frame occupies PER edges from its grant; arbitration is open otherwise.
  int             cyc    = 0;
  int             g_edge = -1000;
  int             last_w = N - 1;
  logic [N-1:0]   e_grant;
  logic [1:0]     e_owner;
  logic [DW-1:0]  e_data;
  logic           e_busy, e_txr, e_txe;

  function automatic int winner(input logic [N-1:0] r, input int last);
`ifdef TX_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  function automatic int oh2i(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic rs);
    int w, dd;
    cyc++;
    e_grant = '0;
    if (!rs) begin
      g_edge = -1000; last_w = N - 1;
      e_owner = '0; e_data = '0; e_busy = 1'b0; e_txr = 1'b1; e_txe = 1'b0;
    end else begin
      dd = cyc - g_edge;
      w  = (dd >= PER) ? winner(r, last_w) : -1;
      if (w >= 0) begin
        g_edge = cyc; last_w = w;
        e_grant = N'(1) << w; e_owner = 2'(w); e_data = d[w*DW +: DW];
        e_busy = 1'b1; e_txr = 1'b1; e_txe = 1'b1;
      end else if (dd >= 1 && dd <= FB) begin
        e_busy = 1'b1; e_txr = 1'b0; e_txe = 1'b1;
      end else if (dd > FB && dd < PER) begin
        e_busy = 1'b1; e_txr = 1'b0; e_txe = 1'b0;
      end else begin
        e_busy = 1'b0; e_txr = 1'b0; e_txe = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0]    r;
    logic [N*DW-1:0] d;
    logic            rs;
    r = bus.req; d = bus.req_data; rs = reset;
    @(posedge clk);
    model_edge(r, d, rs);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; reset0 = 1'b0;
    bus.req = '0; bus.req_data = '0; bus0.req = '0; bus0.req_data = '0;
    tick(); tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_enable !== 1'b0 || bus.grant !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b en=%b grant=%b, expected 0 0 0000", bus.busy, bus.tx_enable, bus.grant);
    end
    checks++;
    if (bus.tx_reset !== 1'b1) begin
      failures++; $display("FAIL reset_txr: tx_reset=%b, expected 1", bus.tx_reset);
    end
    checks++;
    if (bus.owner !== '0 || bus.tx_data !== '0) begin
      failures++; $display("FAIL reset_data: owner=%0d data=%h, expected 0 00", bus.owner, bus.tx_data);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.tx_reset !== 1'b0) begin
      failures++; $display("FAIL reset_release: tx_reset=%b, expected 0", bus.tx_reset);
    end
  endtask

  task automatic test_single();
    logic [N*DW-1:0] d;
    int en_cnt = 0, low_at = -1, held_bad = 0;
    d = $urandom;
    d[2*DW +: DW] = 8'hA5;
    bus.req_data = d; bus.req = 4'b0100;
    tick();
    checks++;
    if (bus.grant !== 4'b0100) begin
      failures++; $display("FAIL single_grant: grant=%b, expected 0100", bus.grant);
    end
    checks++;
    if (bus.owner !== 2'd2 || bus.tx_data !== 8'hA5) begin
      failures++; $display("FAIL single_payload: owner=%0d data=%h, expected 2 a5", bus.owner, bus.tx_data);
    end
    bus.req = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.tx_enable && !bus.tx_reset) en_cnt++;
      if (!bus.busy) begin low_at = k; break; end
      if (bus.tx_data !== 8'hA5 || bus.owner !== 2'd2 || bus.grant !== '0) held_bad++;
    end
    checks++;
    if (en_cnt != FB) begin
      failures++; $display("FAIL single_enable: enabled bits=%0d, expected %0d", en_cnt, FB);
    end
    checks++;
    if (low_at != PER) begin
      failures++; $display("FAIL single_busy: busy low after %0d cycles, expected %0d", low_at, PER);
    end
    checks++;
    if (held_bad != 0) begin
      failures++; $display("FAIL single_hold: %0d cycles with changed data/owner or extra grant, expected 0", held_bad);
    end
  endtask

  task automatic test_round_robin();
    int idx[5], at[5], exp_o[5];
    int n = 0;
    logic [N*DW-1:0] d;
`ifdef TX_ARB_FIXED_PRIO_EN
    exp_o = '{0, 0, 0, 0, 0};
`else
    exp_o = '{0, 1, 2, 3, 0};
`endif
    reset = 1'b0; tick(); reset = 1'b1;
    d = $urandom;
    bus.req_data = d; bus.req = '1;
    for (int k = 0; k < 100 && n < 5; k++) begin
      tick();
      if (bus.grant !== '0) begin
        idx[n] = oh2i(bus.grant); at[n] = cyc;
        checks++;
        if (idx[n] < 0 || bus.tx_data !== d[idx[n]*DW +: DW]) begin
          failures++; $display("FAIL rr_data: grant=%b data=%h", bus.grant, bus.tx_data);
        end
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      failures++; $display("FAIL rr_count: %0d grants seen, expected 5", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (idx[i] != exp_o[i]) begin
        failures++; $display("FAIL rr_order: grant #%0d went to %0d, expected %0d", i, idx[i], exp_o[i]);
      end
      if (i > 0) begin
        checks++;
        if (at[i] - at[i-1] != PER) begin
          failures++; $display("FAIL rr_spacing: %0d cycles, expected %0d", at[i] - at[i-1], PER);
        end
      end
    end
  endtask

  task automatic test_contention();
    int idx[2], at[2], exp_o[2];
    int n = 0;
`ifdef TX_ARB_FIXED_PRIO_EN
    exp_o = '{0, 0};
`else
    exp_o = '{3, 0};
`endif
    bus.req = 4'b1001;
    for (int k = 0; k < 40 && n < 2; k++) begin
      tick();
      if (bus.grant !== '0) begin idx[n] = oh2i(bus.grant); at[n] = cyc; n++; end
    end
    checks++;
    if (n != 2) begin
      failures++; $display("FAIL contend_count: %0d grants seen, expected 2", n);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (idx[i] != exp_o[i]) begin
          failures++; $display("FAIL contend_order: grant #%0d went to %0d, expected %0d", i, idx[i], exp_o[i]);
        end
      end
      checks++;
      if (at[1] - at[0] != PER) begin
        failures++; $display("FAIL contend_spacing: %0d cycles, expected %0d", at[1] - at[0], PER);
      end
    end
  endtask

  task automatic test_withdraw();
    int g1 = 0, gany = 0;
    bus.req = '0;
    for (int k = 0; k < 40 && bus.busy; k++) tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL withdraw_idle: busy=%b after wait, expected 0", bus.busy);
    end
    bus.req = 4'b0001;
    tick();
    checks++;
    if (bus.grant !== 4'b0001) begin
      failures++; $display("FAIL withdraw_start: grant=%b, expected 0001", bus.grant);
    end
    bus.req = '0;
    tick(); tick(); tick();
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.grant[1]) g1++;
      if (bus.grant !== '0) gany++;
    end
    checks++;
    if (g1 != 0 || gany != 0) begin
      failures++; $display("FAIL withdraw_grant: grant[1] pulses=%0d any=%0d, expected 0 0", g1, gany);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL withdraw_busy: busy=%b, expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    bus.req_data = $urandom; bus.req = 4'b0100;
    tick();
    checks++;
    if (bus.grant !== 4'b0100) begin
      failures++; $display("FAIL midrst_start: grant=%b, expected 0100", bus.grant);
    end
    bus.req = '0;
    repeat (6) tick();
    checks++;
    if (bus.tx_enable !== 1'b1 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL midrst_send: en=%b busy=%b, expected 1 1", bus.tx_enable, bus.busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.tx_reset, bus.tx_enable, bus.busy, bus.owner, bus.grant, bus.tx_data} !== {1'b1, 1'b0, 1'b0, 2'd0, 4'b0, 8'h00}) begin
      failures++;
      $display("FAIL midrst_out: txr=%b en=%b busy=%b owner=%0d grant=%b data=%h, expected 1 0 0 0 0000 00",
               bus.tx_reset, bus.tx_enable, bus.busy, bus.owner, bus.grant, bus.tx_data);
    end
    reset = 1'b1; bus.req = '1;
    for (int k = 0; k < 5 && n == 0; k++) begin
      tick();
      if (bus.grant !== '0) n = oh2i(bus.grant) + 1;
    end
    checks++;
    if (n != 1) begin
      failures++; $display("FAIL midrst_first: first grant to %0d, expected 0", n - 1);
    end
    bus.req = '0;
  endtask

  task automatic test_random();
    logic [N-1:0]    r;
    logic [N*DW-1:0] d;
    reset = 1'b0; tick(); reset = 1'b1;
    bus.req = '0;
    for (int k = 0; k < 800; k++) begin
      tick();
      checks++;
      if ({bus.grant, bus.owner, bus.tx_data, bus.busy, bus.tx_reset, bus.tx_enable} !==
          {e_grant, e_owner, e_data, e_busy, e_txr, e_txe}) begin
        failures++;
        $display("FAIL random cyc=%0d: got grant=%b owner=%0d data=%h busy=%b txr=%b en=%b; expected grant=%b owner=%0d data=%h busy=%b txr=%b en=%b",
                 cyc, bus.grant, bus.owner, bus.tx_data, bus.busy, bus.tx_reset, bus.tx_enable,
                 e_grant, e_owner, e_data, e_busy, e_txr, e_txe);
      end
      r = bus.req; d = bus.req_data;
      for (int i = 0; i < N; i++) begin
        if (bus.grant[i]) begin
          r[i] = 1'($urandom_range(0, 1)); d[i*DW +: DW] = DW'($urandom);
        end else if (!r[i]) begin
          if ($urandom_range(0, 3) == 0) begin r[i] = 1'b1; d[i*DW +: DW] = DW'($urandom); end
        end else if ($urandom_range(0, 39) == 0) begin
          r[i] = 1'b0;
        end
      end
      bus.req = r; bus.req_data = d;
      reset = ($urandom_range(0, 149) != 0);
    end
    reset = 1'b1; bus.req = '0;
  endtask

  task automatic test_back_to_back();
    int idx[4], at[4], exp_o[4];
    int n = 0, drops = 0;
`ifdef TX_ARB_FIXED_PRIO_EN
    exp_o = '{0, 0, 0, 0};
`else
    exp_o = '{0, 1, 0, 1};
`endif
    bus0.req_data = $urandom; bus0.req = 4'b0011; reset0 = 1'b1;
    for (int k = 0; k < 80 && n < 4; k++) begin
      tick();
      if (n > 0 && bus0.tx_enable !== 1'b1) drops++;
      if (bus0.grant !== '0) begin idx[n] = oh2i(bus0.grant); at[n] = cyc; n++; end
    end
    checks++;
    if (n != 4) begin
      failures++; $display("FAIL b2b_count: %0d grants seen, expected 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (idx[i] != exp_o[i]) begin
        failures++; $display("FAIL b2b_order: grant #%0d went to %0d, expected %0d", i, idx[i], exp_o[i]);
      end
      if (i > 0) begin
        checks++;
        if (at[i] - at[i-1] != FB + 1) begin
          failures++; $display("FAIL b2b_spacing: %0d cycles, expected %0d", at[i] - at[i-1], FB + 1);
        end
      end
    end
    checks++;
    if (drops != 0) begin
      failures++; $display("FAIL b2b_enable: tx_enable low in %0d cycles between frames, expected 0", drops);
    end
    bus0.req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_contention();
    test_withdraw();
    test_reset_midframe();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
